// File: rtl/reg_file_pkg.sv
// Shared register-file constants used by decode, writeback and the register file itself.
package reg_file_pkg;
  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_DEPTH  = 16;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: reservation sets, writeback clears, and the
// hazard lookup for both read ports.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned DEPTH    = REG_DEPTH,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rdaddrA,
  input  logic [ADDR_W-1:0] rdaddrB,
  input  logic              write,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsvaddr,
  output logic              busyA,
  output logic              busyB,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // A reservation outranks a same-cycle write: it belongs to a newer producer.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ZERO_REG && (i == 0)) begin
        busy_d[i] = 1'b0;
      end else if (rsv && (rsvaddr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (write && (wraddr == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Addresses outside the implemented range never match and so read not-busy.
  always_comb begin
    busyA = 1'b0;
    busyB = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rdaddrA == ADDR_W'(i)) busyA = busy_q[i];
      if (rdaddrB == ADDR_W'(i)) busyB = busy_q[i];
    end
    if (write && (wraddr == rdaddrA)) busyA = 1'b0;
    if (write && (wraddr == rdaddrB)) busyB = 1'b0;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_p.sv
// Parametrised register file: two combinational read ports with write bypass,
// one synchronous write port, and a busy scoreboard for hazard detection.
module reg_file_p
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_DATA_W,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned DEPTH    = REG_DEPTH,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rdaddrA,
  input  logic [ADDR_W-1:0] rdaddrB,
  output logic [DATA_W-1:0] rddataA,
  output logic [DATA_W-1:0] rddataB,
  output logic              busyA,
  output logic              busyB,
  input  logic              write,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsvaddr,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH)) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (write && (wraddr == ADDR_W'(i)) && !(ZERO_REG && (i == 0))) begin
        mem_d[i] = wrdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read muxes; a same-cycle write to the addressed register is forwarded.
  always_comb begin
    rddataA = '0;
    rddataB = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG && (i == 0))) begin
        if (rdaddrA == ADDR_W'(i)) rddataA = mem_q[i];
        if (rdaddrB == ADDR_W'(i)) rddataB = mem_q[i];
      end
    end
    if (write && (wraddr == rdaddrA) && addr_valid(rdaddrA)) rddataA = wrdata;
    if (write && (wraddr == rdaddrB) && addr_valid(rdaddrB)) rddataB = wrdata;
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rdaddrA  (rdaddrA),
    .rdaddrB  (rdaddrB),
    .write    (write),
    .wraddr   (wraddr),
    .rsv      (rsv),
    .rsvaddr  (rsvaddr),
    .busyA    (busyA),
    .busyB    (busyB),
    .busy_vec (busy_vec)
  );

endmodule

// File: doc/reg_file_p.md
# reg_file_p

Parametrised register file for the SAMAB CPU datapath, replacing the fixed 4×16-bit file. It provides two independent combinational read ports, one synchronous write port with write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets issue logic reserve a destination register and detect read-after-write hazards. The block sits between decode (read addresses, reservation) and writeback (write port).

## Interface
Parameters:
- DATA_W, 16, width of each register
- ADDR_W, 4, address width of every port
- DEPTH, 16, number of implemented registers, 1..2**ADDR_W
- ZERO_REG, 0, when 1 register 0 always reads 0, is never written and is never busy

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- rdaddrA  input  ADDR_W  read port A address
- rdaddrB  input  ADDR_W  read port B address
- rddataA  output  DATA_W  read port A data (combinational)
- rddataB  output  DATA_W  read port B data (combinational)
- busyA  output  1  register at rdaddrA has a pending producer
- busyB  output  1  register at rdaddrB has a pending producer
- write  input  1  write enable
- wraddr  input  ADDR_W  write address
- wrdata  input  DATA_W  write data
- rsv  input  1  reserve request: mark rsvaddr busy
- rsvaddr  input  ADDR_W  register to reserve
- busy_vec  output  DEPTH  raw scoreboard state, bit i = register i busy

## Operation
- Storage: DEPTH registers of DATA_W bits. Address is valid when < DEPTH (and != 0 if ZERO_REG=1).
- Write: on a rising edge with write=1 and a valid wraddr, the register takes wrdata. A write to an invalid address is dropped.
- Read: rddataX = wrdata when write=1, wraddr==rdaddrX and the address is valid (bypass). Otherwise rddataX = the stored value. An invalid address reads 0. Both ports are fully independent and may name the same register.
- Scoreboard, per valid register i, next state at each edge:
  - busy[i] set if rsv=1 and rsvaddr==i.
  - Otherwise busy[i] cleared if write=1 and wraddr==i.
  - Otherwise busy[i] holds.
  - Reserve on an invalid address is ignored.
- Reserve and write to the same register in the same cycle: the data is written and busy[i] ends at 1, because the reservation belongs to a newer producer.
- Writing a register that is not busy is legal; busy stays 0.
- busyX = busy[rdaddrX] & ~(write & wraddr==rdaddrX). A same-cycle write clears the hazard because its data is already bypassed. A same-cycle rsv does not affect busyX. An invalid address gives busyX=0.
- busy_vec exposes the raw flops with no bypass applied.

## Timing
- Reset (async assert, removal synchronous to clk): all registers = 0, busy_vec = 0. The outputs follow from this state immediately: rddataA/B = 0 for valid addresses with no write active, busyA/B = 0.
- Write latency: the stored value is visible through the flop path one cycle after the edge. It is visible through bypass in the same cycle write is asserted.
- Reserve latency: busy[i] = 1 from the edge after rsv is sampled.
- rst asserted mid-operation clears everything immediately, regardless of clk. A write or rsv sampled on the same edge as rst is lost.
- There is no handshake or backpressure. Every request is accepted in the cycle it is presented.

## Structure
- Package reg_file_pkg holds the default constants REG_DATA_W=16, REG_ADDR_W=4 and REG_DEPTH=16, shared with decode and writeback.
- Sub-module reg_scoreboard (params ADDR_W, DEPTH, ZERO_REG) holds the busy flops, the set/clear priority and the busyA/busyB lookup. reg_file_p instantiates it and owns storage, bypass and the read multiplexers.

## Test plan
- Reset: write 16'hFFFF to r3, then assert rst for 2 cycles → rddataA (rdaddrA=3) = 0, busy_vec = 0, both during and after reset.
- Write then read: write r5=16'h1234 at cycle n, with rdaddrA=5 and rdaddrB=5 in cycle n → both ports show 16'h1234 in cycle n (bypass) and in n+1 (stored).
- Scoreboard: rsv r7 at n → busy_vec[7]=1 from n+1. Hold rdaddrB=7: busyB=1. Write r7=16'hBEEF at m → busyB=0 in cycle m, busy_vec[7]=0 from m+1.
- Collision: rsv and write both on r2, data 16'h00AA → r2=16'h00AA and busy_vec[2]=1 after the edge.
- ZERO_REG=1, DEPTH=12: write r0=16'h5555 and r13=16'h7777, rsv r0 → reads of r0 and r13 return 0, busyA=0, busy_vec[0]=0.
- Async reset mid-cycle: with r4 busy and holding 16'h0F0F, pulse rst between edges → busy_vec and rddata clear before the next clk edge.
